pc_seq_unit: RTL
================

# pc_seq_unit

Parametrised program-counter unit for the CPU core, the next generation of the PC block. Holds the PC and fetch offset, builds jump targets (restart, interrupt, absolute, relative, register file), and adds a hardware return-address stack so CALL/RET/RETI and interrupt entry can be sequenced without routing the return address through memory on every cycle. Sits between the control unit (select strobes) and the bus/register file (operands).

## Interface
- ADDR_W, 16: PC width in bits; minimum 8.
- OFF_W, 2: fetch offset register width.
- RESET_VECTOR, 'h0100: PC value after reset.
- INT_BASE, 'h0040: interrupt vector base; int target = INT_BASE + int_pc_in*8.
- STACK_DEPTH, 4: return stack entries; power of two, 2..16.

- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- rst_pc_in  in  3  restart index; target = rst_pc_in*8.
- int_pc_in  in  3  interrupt index.
- data_bus  in  8  operand byte from memory.
- reg_file_in  in  ADDR_W  register-file jump target.
- pc_sel  in  4  PC next-value select (see Operation).
- offset_sel  in  2  0 hold, 1 increment, 2 clear, 3 hold.
- write_temp_buf  in  1  latch data_bus into low-byte buffer.
- push_ret  in  1  push return address (pc_w_offset + 1) onto stack.
- pc  out  ADDR_W  current PC register.
- pc_w_offset  out  ADDR_W  pc + zero-extended offset, mod 2^ADDR_W (combinational from registers).
- ret_top  out  ADDR_W  top-of-stack entry; 0 when empty.
- stack_count  out  $clog2(STACK_DEPTH)+1  valid entries.
- stack_full  out  1  stack_count == STACK_DEPTH.
- stack_empty  out  1  stack_count == 0.
- stack_err  out  1  sticky overflow/underflow flag; cleared only by reset.

## Operation
- pc_sel: 0 hold; 1 pc_w_offset+1; 2 restart {rst_pc_in,3'b0} zero-extended; 3 INT_BASE+{int_pc_in,3'b0}; 4 zero; 5 absolute {data_bus, temp_buf} (upper ADDR_W-16 bits zero if ADDR_W>16, truncated if <16); 6 relative pc_w_offset + sign-extended data_bus; 7 reg_file_in; 8 pop: pc <= ret_top, stack pops; 9-15 hold.
- All PC arithmetic modulo 2^ADDR_W: 'hFFFF+1 -> 'h0000 at ADDR_W=16; relative wraps both directions.
- Offset: increment saturates at 2^OFF_W-1 (no wrap); clear/hold as encoded.
- temp_buf: loads data_bus when write_temp_buf=1, else holds. pc_sel=5 in the same cycle uses the old buffer value.
- Return stack: LIFO, STACK_DEPTH entries. push_ret writes pc_w_offset+1 computed from pre-edge registers.
- Push when full: oldest entry discarded, new entry on top, count stays STACK_DEPTH, stack_err <= 1.
- Pop (pc_sel=8) when empty: pc holds, count stays 0, stack_err <= 1.
- push_ret with pc_sel=8 same cycle (non-empty): pc <= old top, new return address replaces top, count unchanged. When empty: underflow rule for pc and stack_err; push proceeds, count becomes 1.
- Stack contents beyond stack_count are don't-care and never visible on ret_top.

## Timing
- Reset (reset=1 at edge): pc=RESET_VECTOR, offset=0, temp_buf=0, stack_count=0, stack_empty=1, stack_full=0, stack_err=0, ret_top=0. Reset overrides all other inputs, including mid-push/pop.
- All selects take effect on the next rising edge: one-cycle latency; pc, ret_top, stack flags valid directly after the edge.
- pc_w_offset and ret_top are registered-state-derived only; no combinational path from any input to any output.
- No handshake: every strobe is a single-cycle command; back-to-back pushes/pops every cycle are supported.

## Test plan
- Reset then hold: reset=1 one cycle, pc_sel=0 -> pc='h0100, pc_w_offset='h0100, stack_empty=1, stack_err=0.
- Offset/increment: offset_sel=1 x4, then pc_sel=1 with offset_sel=2 -> offset saturates at 3, pc='h0104, offset 0.
- Absolute and relative: data_bus='h34 with write_temp_buf=1, then data_bus='h12 pc_sel=5 -> pc='h1234; then data_bus='hFE pc_sel=6 -> pc='h1232; pc='hFFFF, pc_sel=1 -> 'h0000.
- Vectors: rst_pc_in=7 pc_sel=2 -> 'h0038; int_pc_in=2 pc_sel=3 -> 'h0050.
- Stack: at pc='h0200 push_ret x5 (DEPTH=4) -> stack_full=1, stack_err=1, count 4; four pops return newest-first, oldest surviving ='h0201-derived second push; fifth pop -> pc holds, stack_empty=1.
- Simultaneous push+pop, and reset mid-sequence: top='h0300, pc='h0100, push_ret=1 pc_sel=8 -> pc='h0300, ret_top='h0101, count unchanged; reset next cycle -> all reset values.

Source files
------------

// File: rtl/pc_seq_if.sv
// Command/operand and status bundle between the control unit and the program-counter unit.
interface pc_seq_if #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH) + 1;

  logic [2:0]        rst_pc_in;
  logic [2:0]        int_pc_in;
  logic [7:0]        data_bus;
  logic [ADDR_W-1:0] reg_file_in;
  logic [3:0]        pc_sel;
  logic [1:0]        offset_sel;
  logic              write_temp_buf;
  logic              push_ret;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_w_offset;
  logic [ADDR_W-1:0] ret_top;
  logic [CNT_W-1:0]  stack_count;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output rst_pc_in, int_pc_in, data_bus, reg_file_in, pc_sel, offset_sel, write_temp_buf,
           push_ret,
    input  pc, pc_w_offset, ret_top, stack_count, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  rst_pc_in, int_pc_in, data_bus, reg_file_in, pc_sel, offset_sel, write_temp_buf,
           push_ret,
    output pc, pc_w_offset, ret_top, stack_count, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_seq_unit.sv
// Program counter, fetch offset, jump-target mux and hardware return-address stack.
module pc_seq_unit #(
  parameter int unsigned ADDR_W                    = 16,
  parameter int unsigned OFF_W                     = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR        = 'h0100,
  parameter logic [ADDR_W-1:0] INT_BASE            = 'h0040,
  parameter int unsigned STACK_DEPTH               = 4
) (
  input logic     clock,
  input logic     reset,
  pc_seq_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [7:0]        temp_buf_q, temp_buf_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] pc_w_off;
  logic [ADDR_W-1:0] ret_addr;
  logic              empty, full, pop_req, pop_ok, underflow, overflow;

  assign pc_w_off  = pc_q + ADDR_W'(offset_q);
  assign ret_addr  = pc_w_off + ADDR_W'(1);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(STACK_DEPTH));
  assign pop_req   = (bus.pc_sel == 4'd8);
  assign pop_ok    = pop_req && !empty;
  assign underflow = pop_req && empty;
  // A push paired with a successful pop only replaces the top, so it never overflows.
  assign overflow  = bus.push_ret && full && !pop_ok;

  always_comb begin
    pc_d = pc_q;
    unique case (bus.pc_sel)
      4'd1:    pc_d = ret_addr;
      4'd2:    pc_d = ADDR_W'({bus.rst_pc_in, 3'b000});
      4'd3:    pc_d = INT_BASE + ADDR_W'({bus.int_pc_in, 3'b000});
      4'd4:    pc_d = '0;
      4'd5:    pc_d = ADDR_W'({bus.data_bus, temp_buf_q});
      4'd6:    pc_d = pc_w_off + ADDR_W'($signed(bus.data_bus));
      4'd7:    pc_d = bus.reg_file_in;
      4'd8:    pc_d = pop_ok ? stack_q[0] : pc_q;
      default: pc_d = pc_q;
    endcase
  end

  always_comb begin
    offset_d = offset_q;
    unique case (bus.offset_sel)
      2'd1:    offset_d = (offset_q == '1) ? offset_q : offset_q + OFF_W'(1);
      2'd2:    offset_d = '0;
      default: offset_d = offset_q;
    endcase
  end

  assign temp_buf_d = bus.write_temp_buf ? bus.data_bus : temp_buf_q;

  // Entry 0 is the top; pushes shift toward the bottom so the oldest entry falls off when full.
  always_comb begin
    stack_d = stack_q;
    count_d = count_q;
    err_d   = err_q | underflow | overflow;
    if (bus.push_ret && pop_ok) begin
      stack_d[0] = ret_addr;
    end else if (bus.push_ret) begin
      for (int i = int'(STACK_DEPTH) - 1; i > 0; i--) stack_d[i] = stack_q[i-1];
      stack_d[0] = ret_addr;
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop_ok) begin
      for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) stack_d[i] = stack_q[i+1];
      stack_d[STACK_DEPTH-1] = '0;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      offset_q   <= '0;
      temp_buf_q <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      offset_q   <= offset_d;
      temp_buf_q <= temp_buf_d;
      count_q    <= count_d;
      err_q      <= err_d;
      stack_q    <= stack_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_w_offset = pc_w_off;
  assign bus.ret_top     = empty ? '0 : stack_q[0];
  assign bus.stack_count = count_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;
endmodule
